mode_arbiter: RTL and testbench

- Parametrised successor to the piano top-level mode controller.
- Selects the sound and LED source among three modes: free play, auto play and learn.
- Adds the following:
  - an internal free-mode key encoder
  - mode-switch filtering and a muted gap between modes
  - engine start pulses
  - a silent idle state for invalid modes
- Sits between the mode engines (auto, learn), the switch inputs and the tone generator/LED drivers.

---
 rtl/piano_pkg.sv | 22 ++
 rtl/mode_arbiter_key_priority_enc.sv | 28 ++
 rtl/mode_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mode_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared encodings for the piano mode controller: mode one-hot codes,
// arbiter state and the rest note code.
package piano_pkg;

    localparam logic [2:0] MODE_FREE  = 3'b100;
    localparam logic [2:0] MODE_AUTO  = 3'b010;
    localparam logic [2:0] MODE_LEARN = 3'b001;
    localparam logic [2:0] MODE_NONE  = 3'b000;

    localparam int NOTE_REST = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUTE = 2'd1,
        RUN  = 2'd2
    } state_t;

    function automatic logic is_valid_mode(input logic [2:0] m);
        return (m == MODE_FREE) || (m == MODE_AUTO) || (m == MODE_LEARN);
    endfunction

endpackage

// File: rtl/mode_arbiter_key_priority_enc.sv
// Lowest-index key encoder: note = index of lowest pressed key + 1, or 0 when
// no key is pressed. Purely combinational.
module key_priority_enc #(
    parameter int KEY_W  = 7,
    parameter int NOTE_W = 4
) (
    input  logic [KEY_W-1:0]  keys,
    output logic [NOTE_W-1:0] note
);

    // seen[i] = any key below index i pressed; code[i] = result over keys[i-1:0]
    logic [KEY_W:0]      seen;
    logic [NOTE_W-1:0]   code [0:KEY_W];

    assign seen[0] = 1'b0;
    assign code[0] = '0;

    generate
        for (genvar gi = 0; gi < KEY_W; gi++) begin : g_chain
            assign seen[gi+1] = seen[gi] | keys[gi];
            assign code[gi+1] = code[gi] |
                                ((keys[gi] & ~seen[gi]) ? NOTE_W'(gi + 1) : '0);
        end
    endgenerate

    assign note = code[KEY_W];

endmodule

// File: rtl/mode_arbiter.sv
// Piano mode arbiter: filters the mode switches, inserts a muted gap on each
// accepted change, then routes the selected source to the tone/LED outputs.
module mode_arbiter
    import piano_pkg::*;
#(
    parameter int KEY_W         = 7,
    parameter int NOTE_W        = 4,
    parameter int OCT_W         = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int MUTE_CYCLES   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [KEY_W-1:0]  keys,
    input  logic [2:0]        mode,
    input  logic [OCT_W-1:0]  octave_free,
    input  logic [NOTE_W-1:0] note_auto,
    input  logic [KEY_W-1:0]  led_auto,
    input  logic [OCT_W-1:0]  octave_auto,
    input  logic [NOTE_W-1:0] note_learn,
    input  logic [KEY_W-1:0]  led_learn,
    output logic [NOTE_W-1:0] note_out,
    output logic [KEY_W-1:0]  led_out,
    output logic [OCT_W-1:0]  octave_out,
    output logic [2:0]        active_mode,
    output logic              auto_start,
    output logic              learn_start,
    output logic              muted
);

    localparam int SC_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int MC_W = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES - 1);
    localparam logic [MC_W-1:0] MC_MAX = MC_W'(MUTE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [2:0]          candidate_q, candidate_d;
    logic [SC_W-1:0]     stable_cnt_q, stable_cnt_d;
    logic [MC_W-1:0]     mute_cnt_q, mute_cnt_d;
    logic [2:0]          active_mode_q, active_mode_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [KEY_W-1:0]    led_q, led_d;
    logic [OCT_W-1:0]    octave_q, octave_d;
    logic                auto_start_q, auto_start_d;
    logic                learn_start_q, learn_start_d;

    logic [NOTE_W-1:0]   free_note;
    logic [NOTE_W-1:0]   src_note;
    logic [KEY_W-1:0]    src_led;
    logic [OCT_W-1:0]    src_octave;
    logic                accept;

    key_priority_enc #(
        .KEY_W  (KEY_W),
        .NOTE_W (NOTE_W)
    ) u_key_enc (
        .keys (keys),
        .note (free_note)
    );

    always_comb begin
        src_note   = '0;
        src_led    = '0;
        src_octave = '0;
        case (active_mode_q)
            MODE_FREE: begin
                src_note   = free_note;
                src_led    = keys;
                src_octave = octave_free;
            end
            MODE_AUTO: begin
                src_note   = note_auto;
                src_led    = led_auto;
                src_octave = octave_auto;
            end
            MODE_LEARN: begin
                src_note   = note_learn;
                src_led    = led_learn;
                src_octave = '0;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        candidate_d   = candidate_q;
        stable_cnt_d  = stable_cnt_q;
        mute_cnt_d    = mute_cnt_q;
        active_mode_d = active_mode_q;
        note_d        = note_q;
        led_d         = led_q;
        octave_d      = octave_q;
        auto_start_d  = 1'b0;
        learn_start_d = 1'b0;

        if (mode != candidate_q) begin
            candidate_d  = mode;
            stable_cnt_d = '0;
        end else if (stable_cnt_q != SC_MAX) begin
            stable_cnt_d = stable_cnt_q + 1'b1;
        end
        // Judged on the post-edge count so a held mode lands on its Nth sample.
        accept = (stable_cnt_d == SC_MAX) && (candidate_d != active_mode_q);

        case (state_q)
            IDLE: begin
                note_d   = '0;
                led_d    = '0;
                octave_d = '0;
            end
            MUTE: begin
                if (mute_cnt_q == MC_MAX) begin
                    state_d       = RUN;
                    note_d        = src_note;
                    led_d         = src_led;
                    octave_d      = src_octave;
                    auto_start_d  = (active_mode_q == MODE_AUTO);
                    learn_start_d = (active_mode_q == MODE_LEARN);
                end else begin
                    mute_cnt_d = mute_cnt_q + 1'b1;
                end
            end
            RUN: begin
                note_d   = src_note;
                led_d    = src_led;
                octave_d = src_octave;
            end
            default: state_d = IDLE;
        endcase

        if (accept) begin
            auto_start_d  = 1'b0;
            learn_start_d = 1'b0;
            mute_cnt_d    = '0;
            note_d        = NOTE_W'(NOTE_REST);
            led_d         = '0;
            if (is_valid_mode(candidate_d)) begin
                state_d       = MUTE;
                active_mode_d = candidate_d;
                octave_d      = octave_q;
            end else begin
                state_d       = IDLE;
                active_mode_d = MODE_NONE;
                octave_d      = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            candidate_q   <= MODE_NONE;
            stable_cnt_q  <= '0;
            mute_cnt_q    <= '0;
            active_mode_q <= MODE_NONE;
            note_q        <= '0;
            led_q         <= '0;
            octave_q      <= '0;
            auto_start_q  <= 1'b0;
            learn_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            candidate_q   <= candidate_d;
            stable_cnt_q  <= stable_cnt_d;
            mute_cnt_q    <= mute_cnt_d;
            active_mode_q <= active_mode_d;
            note_q        <= note_d;
            led_q         <= led_d;
            octave_q      <= octave_d;
            auto_start_q  <= auto_start_d;
            learn_start_q <= learn_start_d;
        end
    end

    assign note_out    = note_q;
    assign led_out     = led_q;
    assign octave_out  = octave_q;
    assign active_mode = active_mode_q;
    assign auto_start  = auto_start_q;
    assign learn_start = learn_start_q;
    assign muted       = (state_q == MUTE);

endmodule

// File: tb/tb_mode_arbiter.sv
// Directed plus randomized bench for mode_arbiter against a cycle-level
// behavioural model of the mode controller rules.
module tb_mode_arbiter;

    localparam int KEY_W  = 7;
    localparam int NOTE_W = 4;
    localparam int OCT_W  = 2;
    localparam int STABLE = 4;
    localparam int MUTEN  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [KEY_W-1:0]  keys;
    logic [2:0]        mode;
    logic [OCT_W-1:0]  octave_free;
    logic [NOTE_W-1:0] note_auto;
    logic [KEY_W-1:0]  led_auto;
    logic [OCT_W-1:0]  octave_auto;
    logic [NOTE_W-1:0] note_learn;
    logic [KEY_W-1:0]  led_learn;
    logic [NOTE_W-1:0] note_out;
    logic [KEY_W-1:0]  led_out;
    logic [OCT_W-1:0]  octave_out;
    logic [2:0]        active_mode;
    logic              auto_start;
    logic              learn_start;
    logic              muted;

    int checks   = 0;
    int failures = 0;

    // Model state: consecutive-sample run of the mode input, accepted mode,
    // phase (0 idle, 1 muted, 2 playing) and muted cycles spent so far.
    int          m_run;
    logic [2:0]  m_last;
    logic [2:0]  m_acc;
    int          m_phase;
    int          m_mute_spent;
    logic [NOTE_W-1:0] e_note;
    logic [KEY_W-1:0]  e_led;
    logic [OCT_W-1:0]  e_oct;
    logic        e_auto, e_learn;

    int muted_seen, auto_seen, learn_seen;

    mode_arbiter #(
        .KEY_W(KEY_W), .NOTE_W(NOTE_W), .OCT_W(OCT_W),
        .STABLE_CYCLES(STABLE), .MUTE_CYCLES(MUTEN)
    ) dut (
        .clk(clk), .reset(reset), .keys(keys), .mode(mode),
        .octave_free(octave_free), .note_auto(note_auto), .led_auto(led_auto),
        .octave_auto(octave_auto), .note_learn(note_learn), .led_learn(led_learn),
        .note_out(note_out), .led_out(led_out), .octave_out(octave_out),
        .active_mode(active_mode), .auto_start(auto_start),
        .learn_start(learn_start), .muted(muted)
    );

    always #5 clk = ~clk;

    function automatic int lowest_key(input logic [KEY_W-1:0] k);
        for (int i = 0; i < KEY_W; i++)
            if (k[i]) return i + 1;
        return 0;
    endfunction

    function automatic bit one_hot3(input logic [2:0] m);
        return (m == 3'b100) || (m == 3'b010) || (m == 3'b001);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 1; m_last = 3'b000; m_acc = 3'b000; m_phase = 0; m_mute_spent = 0;
        e_note = '0; e_led = '0; e_oct = '0; e_auto = 0; e_learn = 0;
    endtask

    task automatic load_source();
        if (m_acc == 3'b100) begin
            e_note = NOTE_W'(lowest_key(keys)); e_led = keys; e_oct = octave_free;
        end else if (m_acc == 3'b010) begin
            e_note = note_auto; e_led = led_auto; e_oct = octave_auto;
        end else begin
            e_note = note_learn; e_led = led_learn; e_oct = '0;
        end
    endtask

    task automatic model_edge();
        bit acc_now;
        e_auto = 0; e_learn = 0;
        if (reset) begin
            model_reset();
            return;
        end
        if (mode == m_last) m_run++;
        else begin m_run = 1; m_last = mode; end
        acc_now = (m_run >= STABLE) && (m_last != m_acc);
        if (acc_now) begin
            e_note = '0; e_led = '0;
            if (one_hot3(m_last)) begin
                m_acc = m_last; m_phase = 1; m_mute_spent = 1;
            end else begin
                m_acc = 3'b000; m_phase = 0; e_oct = '0;
            end
        end else if (m_phase == 0) begin
            e_note = '0; e_led = '0; e_oct = '0;
        end else if (m_phase == 1) begin
            if (m_mute_spent == MUTEN) begin
                m_phase = 2;
                load_source();
                e_auto  = (m_acc == 3'b010);
                e_learn = (m_acc == 3'b001);
            end else begin
                m_mute_spent++;
            end
        end else begin
            load_source();
        end
    endtask

    // One clock: model consumes the inputs sampled at the edge, then all
    // outputs are compared shortly after the edge.
    task automatic cycle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            model_edge();
            #1;
            chk("note_out",    32'(note_out),    32'(e_note));
            chk("led_out",     32'(led_out),     32'(e_led));
            chk("octave_out",  32'(octave_out),  32'(e_oct));
            chk("active_mode", 32'(active_mode), 32'(m_acc));
            chk("auto_start",  32'(auto_start),  32'(e_auto));
            chk("learn_start", 32'(learn_start), 32'(e_learn));
            chk("muted",       32'(muted),       32'(m_phase == 1));
            muted_seen += int'(muted);
            auto_seen  += int'(auto_start);
            learn_seen += int'(learn_start);
        end
    endtask

    initial begin
        model_reset();
        reset = 1; keys = '0; mode = 3'b000; octave_free = '0;
        note_auto = '0; led_auto = '0; octave_auto = '0;
        note_learn = '0; led_learn = '0;
        muted_seen = 0; auto_seen = 0; learn_seen = 0;
        #2;
        cycle(2);
        $display("step reset: active_mode=%b note=%0d", active_mode, note_out);
        reset = 0;

        // Free mode entry
        mode = 3'b100; keys = 7'b0000100; octave_free = 2'd2;
        cycle(3);
        chk("t1_not_yet", 32'(active_mode), 32'd0);
        cycle(1);
        chk("t1_accept_4th", 32'(active_mode), 32'b100);
        cycle(8);
        chk("t1_note3", 32'(note_out), 32'd3);
        chk("t1_oct2", 32'(octave_out), 32'd2);
        chk("t1_mute8", 32'(muted_seen), 32'd8);
        chk("t1_nopulse", 32'(auto_seen + learn_seen), 32'd0);
        $display("step free: note=%0d led=%b muted_cycles=%0d", note_out, led_out, muted_seen);

        keys = 7'b0010010; cycle(1);
        chk("t2_lowest", 32'(note_out), 32'd2);
        keys = 7'b1111111; cycle(1);
        chk("t2_all", 32'(note_out), 32'd1);
        keys = 7'b1000000; cycle(1);
        chk("t2_top", 32'(note_out), 32'd7);
        keys = 7'b0000000; cycle(1);
        chk("t2_none", 32'(note_out), 32'd0);
        $display("step free keys: note=%0d led=%b", note_out, led_out);

        // Switch to auto
        mode = 3'b010; note_auto = 4'd5; led_auto = 7'b0101010; octave_auto = 2'd1;
        muted_seen = 0; auto_seen = 0;
        cycle(11);
        chk("t3_mute8", 32'(muted_seen), 32'd8);
        cycle(1);
        chk("t3_pulse", 32'(auto_start), 32'd1);
        chk("t3_note5", 32'(note_out), 32'd5);
        led_auto = 7'b1100001; cycle(3);
        chk("t3_one_pulse", 32'(auto_seen), 32'd1);
        chk("t3_led_track", 32'(led_out), 32'b1100001);
        $display("step auto: note=%0d led=%b pulses=%0d", note_out, led_out, auto_seen);

        // Short glitch ignored
        muted_seen = 0;
        mode = 3'b001; cycle(2);
        mode = 3'b010; note_auto = 4'd9; cycle(6);
        chk("t4_no_mute", 32'(muted_seen), 32'd0);
        chk("t4_still_auto", 32'(active_mode), 32'b010);
        $display("step glitch: active_mode=%b note=%0d", active_mode, note_out);

        // Invalid mode during learn mute
        mode = 3'b001; note_learn = 4'd6; led_learn = 7'b0011000;
        cycle(6);
        mode = 3'b110; cycle(4);
        chk("t5_idle", 32'(active_mode), 32'd0);
        chk("t5_zero", 32'(note_out), 32'd0);
        mode = 3'b001; muted_seen = 0; learn_seen = 0;
        cycle(12);
        chk("t5_mute8", 32'(muted_seen), 32'd8);
        chk("t5_pulse", 32'(learn_start), 32'd1);
        $display("step learn: active_mode=%b note=%0d", active_mode, note_out);

        // Reset mid-run
        keys = 7'b0001000; cycle(3);
        reset = 1; cycle(1);
        chk("t6_rst_note", 32'(note_out), 32'd0);
        chk("t6_rst_mode", 32'(active_mode), 32'd0);
        reset = 0; learn_seen = 0;
        cycle(12);
        chk("t6_pulse", 32'(learn_seen), 32'd1);
        $display("step reset-run: active_mode=%b note=%0d", active_mode, note_out);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            int hold;
            logic [2:0] pick [6];
            pick[0] = 3'b100; pick[1] = 3'b010; pick[2] = 3'b001;
            pick[3] = 3'b000; pick[4] = 3'b110; pick[5] = 3'b111;
            mode = (t % 3 == 2) ? pick[$urandom_range(0, 5)] : pick[$urandom_range(0, 2)];
            hold = $urandom_range(1, 16);
            for (int h = 0; h < hold; h++) begin
                keys = KEY_W'($urandom); octave_free = OCT_W'($urandom);
                note_auto = NOTE_W'($urandom); led_auto = KEY_W'($urandom);
                octave_auto = OCT_W'($urandom); note_learn = NOTE_W'($urandom);
                led_learn = KEY_W'($urandom);
                reset = ($urandom_range(0, 99) == 0);
                cycle(1);
            end
            reset = 0;
            $display("step random %0d: mode=%b hold=%0d active_mode=%b", t, mode, hold, active_mode);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
